// File: rtl/wb_port_arbiter_if.sv
// Bundle of write-back stage, MDU result and register-file write signals for wb_port_arbiter.
// master drives the pipeline/MDU results; slave is the arbiter side.
interface wb_port_arbiter_if #(
  parameter int unsigned XLEN = 64
);
  logic            pipe_valid;
  logic [4:0]      pipe_rd;
  logic [XLEN-1:0] pipe_data;
  logic            mdu_valid;
  logic [4:0]      mdu_rd;
  logic [XLEN-1:0] mdu_data;
  logic            mdu_ready;
  logic            rf_we;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_wd;
  logic            wb_stall;

  modport master (
    output pipe_valid, pipe_rd, pipe_data, mdu_valid, mdu_rd, mdu_data,
    input  mdu_ready, rf_we, rf_rd, rf_wd, wb_stall
  );

  modport slave (
    input  pipe_valid, pipe_rd, pipe_data, mdu_valid, mdu_rd, mdu_data,
    output mdu_ready, rf_we, rf_rd, rf_wd, wb_stall
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares one register-file write port between the write-back stage and a 2-deep MDU result FIFO.
// Define WB_ARB_BYPASS_EN to let an MDU result go straight to rf_* when the port is otherwise idle.
module wb_port_arbiter #(
  parameter int unsigned XLEN         = 64,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic              clock,
  input logic              reset,
  wb_port_arbiter_if.slave bus
);

  localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT - 1);

  logic [4:0]      fifo_rd_q   [2];
  logic [XLEN-1:0] fifo_data_q [2];
  logic            wr_ptr_q, rd_ptr_q;
  logic [1:0]      count_q, count_d;
  logic [3:0]      starve_q, starve_d;
  logic            stall_q, stall_d;
  logic            rf_we_q, rf_we_d;
  logic [4:0]      rf_rd_q, rf_rd_d;
  logic [XLEN-1:0] rf_wd_q, rf_wd_d;
  logic            mdu_ready;
  logic            mdu_acc, pipe_req, head_grant, byp_grant, enq;

  assign mdu_ready     = !reset && (count_q < 2'd2);
  assign bus.mdu_ready = mdu_ready;
  assign bus.rf_we     = rf_we_q;
  assign bus.rf_rd     = rf_rd_q;
  assign bus.rf_wd     = rf_wd_q;
  assign bus.wb_stall  = stall_q;

  always_comb begin
    mdu_acc    = bus.mdu_valid && mdu_ready && (bus.mdu_rd != 5'd0);
    pipe_req   = bus.pipe_valid && (bus.pipe_rd != 5'd0) && !stall_q;
    head_grant = !pipe_req && (count_q != 2'd0);
`ifdef WB_ARB_BYPASS_EN
    byp_grant  = !pipe_req && (count_q == 2'd0) && mdu_acc;
`else
    byp_grant  = 1'b0;
`endif
    enq        = mdu_acc && !byp_grant;

    rf_we_d = 1'b1;
    rf_rd_d = rf_rd_q;
    rf_wd_d = rf_wd_q;
    if (pipe_req) begin
      rf_rd_d = bus.pipe_rd;
      rf_wd_d = bus.pipe_data;
    end else if (head_grant) begin
      rf_rd_d = fifo_rd_q[rd_ptr_q];
      rf_wd_d = fifo_data_q[rd_ptr_q];
    end else if (byp_grant) begin
      rf_rd_d = bus.mdu_rd;
      rf_wd_d = bus.mdu_data;
    end else begin
      rf_we_d = 1'b0;
    end

    count_d  = count_q + {1'b0, enq} - {1'b0, head_grant};
    starve_d = (head_grant || (count_q == 2'd0)) ? 4'd0 : starve_q + 4'd1;
    // One-cycle stall pulse; the following edge always grants the head, which clears it.
    stall_d  = (count_q != 2'd0) && !head_grant && (starve_q == StarveMax);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      starve_q <= 4'd0;
      stall_q  <= 1'b0;
      rf_we_q  <= 1'b0;
      rf_rd_q  <= 5'd0;
      rf_wd_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q ^ enq;
      rd_ptr_q <= rd_ptr_q ^ head_grant;
      count_q  <= count_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
      rf_we_q  <= rf_we_d;
      rf_rd_q  <= rf_rd_d;
      rf_wd_q  <= rf_wd_d;
    end
  end

  // Payload storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clock) begin
    if (enq) begin
      fifo_rd_q[wr_ptr_q]   <= bus.mdu_rd;
      fifo_data_q[wr_ptr_q] <= bus.mdu_data;
    end
  end

endmodule
